// File: rtl/r_sync_pkg.sv
// Shared constants and helpers for the read-domain multi-channel
// Gray write-pointer synchronizer.
package r_sync_pkg;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;
   localparam int PTR_MAX         = 32;

   function automatic int pw_of(input int aw);
      return aw + 1;
   endfunction

   function automatic int depth_of(input int aw);
      return 1 << aw;
   endfunction

   // Zero-extended upper bits do not disturb the prefix XOR, so one
   // wide implementation serves every pointer width.
   function automatic logic [PTR_MAX-1:0] gray2bin(
      input logic [PTR_MAX-1:0] g
   );
      logic [PTR_MAX-1:0] b;
      b[PTR_MAX-1] = g[PTR_MAX-1];
      for (int i = PTR_MAX - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/r_sync_chan.sv
// One pointer channel: synchronizer chain, Gray decode, advance
// measurement and sticky over-advance error.
module r_sync_chan
   import r_sync_pkg::*;
#(
   parameter int ADDR_WIDTH  = 3,
   parameter int SYNC_STAGES = 2,
   localparam int PW         = ADDR_WIDTH + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          warm,
   input  logic [PW-1:0] ptr,
   input  logic          clr,
   output logic [PW-1:0] gr,
   output logic [PW-1:0] bin,
   output logic [PW-1:0] adv,
   output logic          pulse,
   output logic          err
);

   localparam logic [PW-1:0] DEPTH = PW'(depth_of(ADDR_WIDTH));

   logic [PW-1:0] s [SYNC_STAGES];
   logic [PW-1:0] b;
   logic [PW-1:0] d;
   logic          set;

   assign gr = s[SYNC_STAGES-1];

   always_comb begin
      b   = PW'(gray2bin(PTR_MAX'(gr)));
      d   = b - bin;
      set = warm && (d > DEPTH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            s[i] <= '0;
         end
         bin   <= '0;
         adv   <= '0;
         pulse <= 1'b0;
         err   <= 1'b0;
      end else begin
         s[0] <= ptr;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            s[i] <= s[i-1];
         end
         bin   <= b;
         adv   <= d;
         pulse <= warm && (d != '0);
         // A fresh violation outranks a clear on the same edge.
         if (set) begin
            err <= 1'b1;
         end else if (clr) begin
            err <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/r_sync_ptr_multi.sv
// NUM_CH independent Gray write-pointer synchronizers into r_clk,
// sharing one post-reset warm-up counter.
module r_sync_ptr_multi
   import r_sync_pkg::*;
#(
   parameter int ADDR_WIDTH  = 3,
   parameter int NUM_CH      = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                           r_clk,
   input  logic                           r_rst,
   input  logic [NUM_CH*(ADDR_WIDTH+1)-1:0] unsync_w_ptr,
   input  logic [NUM_CH-1:0]              err_clr,
   output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] sync_gr_w_ptr,
   output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] sync_bin_w_ptr,
   output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] ptr_adv,
   output logic [NUM_CH-1:0]              adv_pulse,
   output logic [NUM_CH-1:0]              ovr_err,
   output logic                           warm
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam int CW = $clog2(SYNC_STAGES_MAX + 1);

   if (SYNC_STAGES < SYNC_STAGES_MIN ||
       SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("r_sync_ptr_multi: SYNC_STAGES must be 2..4");
   end

   if (PW > PTR_MAX || NUM_CH < 1) begin : g_bad_width
      $error("r_sync_ptr_multi: bad ADDR_WIDTH or NUM_CH");
   end

   logic [CW-1:0] cnt;

   // warm rises once SYNC_STAGES+1 edges have passed since release,
   // i.e. when the first real capture reaches the binary register.
   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         cnt  <= '0;
         warm <= 1'b0;
      end else if (!warm) begin
         cnt <= cnt + CW'(1);
         if (cnt == CW'(SYNC_STAGES)) begin
            warm <= 1'b1;
         end
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      r_sync_chan #(
         .ADDR_WIDTH  (ADDR_WIDTH),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk   (r_clk),
         .rst   (r_rst),
         .warm  (warm),
         .ptr   (unsync_w_ptr[c*PW +: PW]),
         .clr   (err_clr[c]),
         .gr    (sync_gr_w_ptr[c*PW +: PW]),
         .bin   (sync_bin_w_ptr[c*PW +: PW]),
         .adv   (ptr_adv[c*PW +: PW]),
         .pulse (adv_pulse[c]),
         .err   (ovr_err[c])
      );
   end

endmodule

// File: tb/tb_r_sync_ptr_multi.sv
// Directed bench: per-edge vector table plus hand sequences for wrap,
// overflow, mid-run reset and a wide/deep configuration.
module tb_r_sync_ptr_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] ptr;
   logic [1:0] clr;
   logic [7:0] gr, bin, adv;
   logic [1:0] pulse, err;
   logic       warm;

   logic       rst_b;
   logic [5:0] ptr_b;
   logic [0:0] clr_b;
   logic [5:0] gr_b, bin_b, adv_b;
   logic [0:0] pulse_b, err_b;
   logic       warm_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   r_sync_ptr_multi #(
      .ADDR_WIDTH(3), .NUM_CH(2), .SYNC_STAGES(2)
   ) dut (
      .r_clk(clk), .r_rst(rst), .unsync_w_ptr(ptr), .err_clr(clr),
      .sync_gr_w_ptr(gr), .sync_bin_w_ptr(bin), .ptr_adv(adv),
      .adv_pulse(pulse), .ovr_err(err), .warm(warm)
   );

   r_sync_ptr_multi #(
      .ADDR_WIDTH(5), .NUM_CH(1), .SYNC_STAGES(4)
   ) dut_b (
      .r_clk(clk), .r_rst(rst_b), .unsync_w_ptr(ptr_b),
      .err_clr(clr_b), .sync_gr_w_ptr(gr_b),
      .sync_bin_w_ptr(bin_b), .ptr_adv(adv_b),
      .adv_pulse(pulse_b), .ovr_err(err_b), .warm(warm_b)
   );

   typedef struct {
      logic       rst;
      logic [3:0] g0, g1;
      logic [1:0] clr;
      logic [3:0] gr0, bin0, adv0, bin1;
      logic [1:0] pulse, err;
      logic       warm;
   } vec_t;

   vec_t tbl [22];

   function automatic logic [3:0] g4(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic reset_to(input logic [3:0] b0, input logic [3:0] b1);
      rst = 1'b1;
      ptr = {g4(b1), g4(b0)};
      tick();
      rst = 1'b0;
      ticks(3);
      chk("reset_to warm/bin", {warm, bin}, {1'b1, b1, b0});
   endtask

   initial begin
      rst   = 1'b1;
      ptr   = '0;
      clr   = '0;
      rst_b = 1'b1;
      ptr_b = '0;
      clr_b = '0;

      //        rst g0 g1 clr gr0 bin0 adv0 bin1 pul err warm
      tbl[0]  = '{1, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[3]  = '{0, 6, 3, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[4]  = '{0, 6, 3, 0, 6, 0, 0, 0, 0, 0, 0};
      tbl[5]  = '{0, 6, 3, 0, 6, 4, 4, 2, 0, 0, 1};
      tbl[6]  = '{1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[7]  = '{0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[8]  = '{0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[9]  = '{0, 0, 3, 0, 0, 0, 0, 2, 0, 0, 1};
      tbl[10] = '{0, 1, 3, 0, 0, 0, 0, 2, 0, 0, 1};
      tbl[11] = '{0, 1, 3, 0, 1, 0, 0, 2, 0, 0, 1};
      tbl[12] = '{0, 1, 3, 0, 1, 1, 1, 2, 1, 0, 1};
      tbl[13] = '{0, 1, 3, 0, 1, 1, 0, 2, 0, 0, 1};
      tbl[14] = '{0, 3, 3, 0, 1, 1, 0, 2, 0, 0, 1};
      tbl[15] = '{0, 3, 3, 0, 3, 1, 0, 2, 0, 0, 1};
      tbl[16] = '{0, 3, 3, 0, 3, 2, 1, 2, 1, 0, 1};
      tbl[17] = '{0, 3, 3, 0, 3, 2, 0, 2, 0, 0, 1};
      tbl[18] = '{0, 2, 3, 0, 3, 2, 0, 2, 0, 0, 1};
      tbl[19] = '{0, 2, 3, 0, 2, 2, 0, 2, 0, 0, 1};
      tbl[20] = '{0, 2, 3, 0, 2, 3, 1, 2, 1, 0, 1};
      tbl[21] = '{0, 2, 3, 0, 2, 3, 0, 2, 0, 0, 1};

      @(negedge clk);
      for (int i = 0; i < 22; i++) begin
         rst = tbl[i].rst;
         ptr = {tbl[i].g1, tbl[i].g0};
         clr = tbl[i].clr;
         tick();
         chk($sformatf("row%0d", i),
             {gr[3:0], bin[3:0], adv[3:0], bin[7:4],
              pulse, err, warm},
             {tbl[i].gr0, tbl[i].bin0, tbl[i].adv0, tbl[i].bin1,
              tbl[i].pulse, tbl[i].err, tbl[i].warm});
      end

      // wrap 14 -> 1
      reset_to(14, 0);
      ptr[3:0] = g4(1);
      ticks(3);
      chk("wrap adv/pulse/err", {adv[3:0], pulse, err},
          {4'd3, 2'b01, 2'b00});

      // advance of exactly the depth is legal
      reset_to(0, 0);
      ptr[3:0] = g4(8);
      ticks(3);
      chk("full adv/pulse/err", {adv[3:0], pulse, err},
          {4'd8, 2'b01, 2'b00});

      // overflow on ch0 alongside a legal step on ch1
      reset_to(0, 0);
      ptr = {g4(4), g4(9)};
      ticks(3);
      chk("ovr set", {adv, pulse, err},
          {4'd4, 4'd9, 2'b11, 2'b01});
      tick();
      chk("ovr hold", {pulse, err}, {2'b00, 2'b01});
      clr = 2'b01;
      tick();
      clr = 2'b00;
      chk("ovr clr", err, 2'b00);
      clr = 2'b01;
      ptr[3:0] = g4(2);
      ticks(3);
      chk("set beats clr", {adv[3:0], err}, {4'd9, 2'b01});
      clr = 2'b00;
      tick();
      chk("ovr sticky", err, 2'b01);

      // reset in the middle of operation
      reset_to(0, 0);
      ptr = {g4(5), g4(5)};
      ticks(3);
      chk("pre-reset bin", bin, {4'd5, 4'd5});
      rst = 1'b1;
      ptr = '0;
      tick();
      chk("mid reset zero", {gr, bin, adv, pulse, err, warm}, 29'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk($sformatf("warmup quiet%0d", i), {pulse, err}, 4'd0);
      end
      chk("warm after reset", warm, 1'b1);

      // deep/wide configuration: 4 stages, depth 32
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      ticks(4);
      chk("b warm early", warm_b, 1'b0);
      tick();
      chk("b warm", warm_b, 1'b1);
      ptr_b = 6'b110000;
      ticks(4);
      chk("b gray latency", {gr_b, bin_b}, {6'b110000, 6'd0});
      tick();
      chk("b full legal", {bin_b, adv_b, pulse_b, err_b},
          {6'd32, 6'd32, 1'b1, 1'b0});
      ptr_b = 6'b000001;
      ticks(5);
      chk("b overflow", {bin_b, adv_b, pulse_b, err_b},
          {6'd1, 6'd33, 1'b1, 1'b1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
